// File: rtl/vec_sequencer.sv
// Vector instruction sequencer: steps element indices and memory/VRF strobes for one decoded op.
// Optional build macro VSEQ_ABORT_EN adds an abort input that cancels a running op.
module vec_sequencer (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VSEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic        instr_valid,
  input  logic [3:0]  functype,
  input  logic        v_en,
  input  logic [4:0]  cycleCount,
  input  logic [5:0]  offset,
  input  logic [2:0]  dstAddr,
  input  logic [2:0]  addr1,
  input  logic [2:0]  addr2,
  input  logic [15:0] base_data,
  output logic        busy,
  output logic [3:0]  rd_idx,
  output logic [3:0]  wr_idx,
  output logic        vrf_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [2:0]  dst_q,
  output logic [2:0]  src1_q,
  output logic [2:0]  src2_q,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for an instruction
  // RUN   | stepping elements, busy=1
  // FIN   | one-cycle done pulse, may accept the next instruction
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

  localparam logic [3:0] OP_VADD = 4'd1;
  localparam logic [3:0] OP_VLD  = 4'd2;
  localparam logic [3:0] OP_VST  = 4'd3;
  localparam logic [3:0] OP_SMUL = 4'd4;
  localparam logic [3:0] OP_SST  = 4'd5;

  state_t      state_q, state_d;
  logic [3:0]  func_q;
  logic        ven_q;
  logic [15:0] off_q;
  logic [15:0] base_q;
  logic [4:0]  rem_q;
  logic [4:0]  step_q;
  logic        run;
  logic        accept;
  logic        abort_w;

`ifdef VSEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign run    = (state_q == S_RUN);
  assign accept = instr_valid && !run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (abort_w)          state_d = S_IDLE;
        else if (rem_q == '0) state_d = S_FIN;
      end
      S_FIN:   state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q <= '0;
      ven_q  <= 1'b0;
      off_q  <= '0;
      base_q <= '0;
      rem_q  <= '0;
      step_q <= '0;
      dst_q  <= '0;
      src1_q <= '0;
      src2_q <= '0;
    end else if (accept) begin
      func_q <= functype;
      ven_q  <= v_en;
      off_q  <= {{10{offset[5]}}, offset};
      base_q <= base_data;
      rem_q  <= cycleCount;
      step_q <= '0;
      dst_q  <= dstAddr;
      src1_q <= addr1;
      src2_q <= addr2;
    end else if (run) begin
      step_q <= step_q + 5'd1;
      if (rem_q != '0) rem_q <= rem_q - 5'd1;
    end
  end

  always_comb begin
    busy     = run;
    done     = (state_q == S_FIN);
    rd_idx   = run ? step_q[3:0] : 4'd0;
    mem_addr = run ? (base_q + off_q + {12'd0, step_q[3:0]}) : 16'd0;
    wr_idx   = 4'd0;
    vrf_we   = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if (run) begin
      case (func_q)
        // write-back trails the read by one step
        OP_VADD, OP_VLD: begin
          if (step_q != 5'd0 && step_q <= 5'd16) begin
            vrf_we = ven_q;
            wr_idx = step_q[3:0] - 4'd1;
          end
          if (func_q == OP_VLD) mem_re = !step_q[4];
        end
        OP_SMUL: begin
          if (!step_q[4]) begin
            vrf_we = ven_q;
            wr_idx = step_q[3:0];
          end
        end
        OP_VST:  mem_we = !step_q[4];
        OP_SST:  mem_we = (step_q == 5'd0);
        default: ;
      endcase
    end
  end

endmodule
